// File: rtl/s_term_pipe_switch_matrix_if.sv
// ----------------------------------------------------------------------------
// s_term_pipe_switch_matrix_if
// Channel and configuration-chain bundle for the south-terminal switch matrix.
//
//   from_S       channel inputs from the tile below
//   to_N         channel outputs to the tile above
//   cfg_shift_en shift cfg_din into the shadow chain
//   cfg_din      serial configuration bit
//   cfg_dout     shadow chain MSB (daisy-chain output)
//   cfg_commit   request shadow -> active copy
//   cfg_full     shadow chain holds a complete new configuration
//   cfg_done     one-cycle pulse, commit accepted
//   cfg_err      one-cycle pulse, commit rejected
//
// master: the side driving channel inputs and the configuration chain.
// slave : the switch matrix itself.
// ----------------------------------------------------------------------------
interface s_term_pipe_switch_matrix_if #(
    parameter int NUM_WIRES = 48
);
    logic [NUM_WIRES-1:0] from_S;
    logic [NUM_WIRES-1:0] to_N;
    logic                 cfg_shift_en;
    logic                 cfg_din;
    logic                 cfg_dout;
    logic                 cfg_commit;
    logic                 cfg_full;
    logic                 cfg_done;
    logic                 cfg_err;

    modport master (
        output from_S, cfg_shift_en, cfg_din, cfg_commit,
        input  to_N, cfg_dout, cfg_full, cfg_done, cfg_err
    );

    modport slave (
        input  from_S, cfg_shift_en, cfg_din, cfg_commit,
        output to_N, cfg_dout, cfg_full, cfg_done, cfg_err
    );
endinterface

// File: rtl/s_term_pipe_switch_matrix.sv
// ----------------------------------------------------------------------------
// s_term_pipe_switch_matrix
// South-terminal switch matrix: NUM_WIRES S->N channels, each individually
// configured as combinational pass, PIPE_DEPTH-stage retimed, tied low or
// frozen. Channel modes come from a serially loaded, double-buffered chain.
//
// Ports:
//   UserCLK   fabric user clock, all state on the rising edge
//   UserRSTn  asynchronous active-low reset
//   bus       s_term_pipe_switch_matrix_if.slave (channels + config chain)
//
// Parameters:
//   NUM_WIRES   number of channels (index 0 = SA0 ... 47 = SI11)
//   PIPE_DEPTH  retiming stages in registered mode, 1..4
//
// Optional feature (macro SAUBER_TERM_CFG_PARITY_EN):
//   Adds an even-parity bit at the LSB of the chain; commits with odd total
//   parity are rejected. Channel modes then sit one bit higher in the chain.
//
// Mode encoding per channel: 00 pass, 01 reg, 10 tie low, 11 hold.
// ----------------------------------------------------------------------------
module s_term_pipe_switch_matrix #(
    parameter int NUM_WIRES  = 48,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                         UserCLK,
    input  logic                         UserRSTn,
    s_term_pipe_switch_matrix_if.slave   bus
);

`ifdef SAUBER_TERM_CFG_PARITY_EN
    localparam int CFG_BITS = 2*NUM_WIRES + 1;
    localparam int MODE_OFS = 1;
`else
    localparam int CFG_BITS = 2*NUM_WIRES;
    localparam int MODE_OFS = 0;
`endif
    localparam int CNT_W = $clog2(CFG_BITS + 1);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_TIE  = 2'b10;

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
            $error("PIPE_DEPTH must be in 1..4");
        end
    endgenerate

    logic [CFG_BITS-1:0]  shadow;
    logic [CFG_BITS-1:0]  active;
    logic [CNT_W-1:0]     cnt;
    logic                 done_q;
    logic                 err_q;
    logic                 full;
    logic                 parity_ok;
    logic                 accept;
    logic [NUM_WIRES-1:0] pipe [PIPE_DEPTH];
    logic [NUM_WIRES-1:0] hold_mask;
    logic [NUM_WIRES-1:0] to_n;

    assign full = (cnt == CNT_W'(CFG_BITS));

`ifdef SAUBER_TERM_CFG_PARITY_EN
    assign parity_ok = ~^shadow;
`else
    assign parity_ok = 1'b1;
`endif

    assign accept = bus.cfg_commit & full & parity_ok;

    // Per-channel output select; hold channels also freeze their pipe.
    always_comb begin
        hold_mask = '0;
        to_n      = '0;
        for (int i = 0; i < NUM_WIRES; i++) begin
            case (active[2*i+MODE_OFS +: 2])
                MODE_PASS: to_n[i] = bus.from_S[i];
                MODE_REG:  to_n[i] = pipe[PIPE_DEPTH-1][i];
                MODE_TIE:  to_n[i] = 1'b0;
                default: begin
                    to_n[i]      = pipe[PIPE_DEPTH-1][i];
                    hold_mask[i] = 1'b1;
                end
            endcase
        end
    end

    // Retiming pipe: runs in every mode except hold, so switching a channel
    // to reg mode produces valid data after PIPE_DEPTH cycles.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            for (int k = 0; k < PIPE_DEPTH; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= (pipe[0] & hold_mask) | (bus.from_S & ~hold_mask);
            for (int k = 1; k < PIPE_DEPTH; k++)
                pipe[k] <= (pipe[k] & hold_mask) | (pipe[k-1] & ~hold_mask);
        end
    end

    // Configuration chain. Commit wins over a simultaneous shift and sees the
    // pre-shift shadow; the shadow is kept after a commit for daisy-chaining.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.cfg_commit) begin
                if (accept) begin
                    active <= shadow;
                    cnt    <= '0;
                    done_q <= 1'b1;
                end else begin
                    err_q  <= 1'b1;
                end
            end else if (bus.cfg_shift_en) begin
                shadow <= {shadow[CFG_BITS-2:0], bus.cfg_din};
                if (!full) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.to_N     = to_n;
    assign bus.cfg_dout = shadow[CFG_BITS-1];
    assign bus.cfg_full = full;
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_s_term_pipe_switch_matrix.sv
module tb_s_term_pipe_switch_matrix;
    localparam int NW = 48;
    localparam int PD = 2;
`ifdef SAUBER_TERM_CFG_PARITY_EN
    localparam int CFG_BITS = 2*NW + 1;
`else
    localparam int CFG_BITS = 2*NW;
`endif

    logic UserCLK = 1'b0;
    logic UserRSTn;

    s_term_pipe_switch_matrix_if #(.NUM_WIRES(NW)) bus();

    s_term_pipe_switch_matrix #(.NUM_WIRES(NW), .PIPE_DEPTH(PD)) dut (
        .UserCLK  (UserCLK),
        .UserRSTn (UserRSTn),
        .bus      (bus)
    );

    always #5 UserCLK = ~UserCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the chain is the list of the last CFG_BITS bits shifted
    // (front = oldest = MSB), and each channel keeps a FIFO of its last PD
    // accepted samples, whose front is what reg/hold mode shows.
    bit sh_q[$];
    int m_cnt;
    int m_mode [NW];
    bit pq [NW][$];
    bit m_done, m_err;

    task automatic model_reset();
        sh_q.delete();
        repeat (CFG_BITS) sh_q.push_back(1'b0);
        m_cnt = 0;
        for (int i = 0; i < NW; i++) begin
            m_mode[i] = 0;
            pq[i].delete();
            repeat (PD) pq[i].push_back(1'b0);
        end
        m_done = 0;
        m_err  = 0;
    endtask

    function automatic bit chain_bit(int p);
        return sh_q[CFG_BITS-1-p];
    endfunction

    function automatic logic [NW-1:0] exp_to_n();
        logic [NW-1:0] r;
        for (int i = 0; i < NW; i++) begin
            if (m_mode[i] == 0)      r[i] = bus.from_S[i];
            else if (m_mode[i] == 2) r[i] = 1'b0;
            else                     r[i] = pq[i][0];
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_flags();
        return {sh_q[0], (m_cnt == CFG_BITS), m_done, m_err};
    endfunction

    function automatic logic [NW-1:0] rnd_w();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[NW-1:0];
    endfunction

    function automatic logic [2*NW-1:0] uniform_modes(logic [1:0] m);
        logic [2*NW-1:0] v;
        for (int i = 0; i < NW; i++) v[2*i +: 2] = m;
        return v;
    endfunction

    // Advance one clock: update the model from the inputs in force, then
    // return 1 time unit after the edge.
    task automatic tick();
        logic [NW-1:0] fs;
        bit par;
        int ofs;
        fs  = bus.from_S;
        ofs = CFG_BITS - 2*NW;
        for (int i = 0; i < NW; i++) begin
            if (m_mode[i] != 3) begin
                pq[i].push_back(fs[i]);
                void'(pq[i].pop_front());
            end
        end
        m_done = 0;
        m_err  = 0;
        par = 0;
        foreach (sh_q[j]) par ^= sh_q[j];
`ifndef SAUBER_TERM_CFG_PARITY_EN
        par = 0;
`endif
        if (bus.cfg_commit) begin
            if (m_cnt == CFG_BITS && par == 0) begin
                for (int i = 0; i < NW; i++)
                    m_mode[i] = 2*int'(chain_bit(2*i+1+ofs)) + int'(chain_bit(2*i+ofs));
                m_cnt  = 0;
                m_done = 1;
            end else begin
                m_err = 1;
            end
        end else if (bus.cfg_shift_en) begin
            sh_q.push_back(bus.cfg_din);
            void'(sh_q.pop_front());
            if (m_cnt < CFG_BITS) m_cnt++;
        end
        @(posedge UserCLK);
        #1;
    endtask

    function automatic logic [CFG_BITS-1:0] chain_word(logic [2*NW-1:0] modes, bit bad_par);
`ifdef SAUBER_TERM_CFG_PARITY_EN
        return {modes, (^modes) ^ bad_par};
`else
        return modes;
`endif
    endfunction

    // Shift nbits of word, MSB first; all channel inputs toggle every cycle.
    task automatic shift_word(logic [CFG_BITS-1:0] w, int nbits);
        for (int b = CFG_BITS-1; b > CFG_BITS-1-nbits; b--) begin
            bus.cfg_shift_en = 1'b1;
            bus.cfg_din      = w[b];
            bus.from_S       = ~bus.from_S;
            tick();
        end
        bus.cfg_shift_en = 1'b0;
        bus.cfg_din      = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    task automatic test_reset();
        UserRSTn         = 1'b0;
        bus.cfg_shift_en = 1'b0;
        bus.cfg_din      = 1'b0;
        bus.cfg_commit   = 1'b0;
        bus.from_S       = 48'h0123_4567_89AB;
        model_reset();
        #1;
        n_checks++;
        if (bus.to_N !== 48'h0123_4567_89AB) begin
            n_fail++; $display("FAIL reset_pass: to_N=%h required %h", bus.to_N, 48'h0123_4567_89AB);
        end
        n_checks++;
        if ({bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_cfg_outs: {dout,full,done,err}=%b required 0000",
                               {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err});
        end
        repeat (2) @(posedge UserCLK);
        #1 UserRSTn = 1'b1;
        bus.from_S = 48'hA5A5_0F0F_1234;
        #1;
        n_checks++;
        if (bus.to_N !== 48'hA5A5_0F0F_1234) begin
            n_fail++; $display("FAIL post_reset_pass: to_N=%h required %h", bus.to_N, 48'hA5A5_0F0F_1234);
        end
        n_checks++;
        if ({bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err} !== 4'b0000) begin
            n_fail++; $display("FAIL post_reset_cfg_outs: got %b required 0000",
                               {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err});
        end
        @(posedge UserCLK);
        #1;
    endtask

    task automatic test_all_reg();
        shift_word(chain_word(uniform_modes(2'b01), 1'b0), CFG_BITS);
        n_checks++;
        if (bus.cfg_full !== 1'b1) begin
            n_fail++; $display("FAIL full_after_load: cfg_full=%b required 1", bus.cfg_full);
        end
        pulse_commit();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err, bus.cfg_full} !== 3'b100) begin
            n_fail++; $display("FAIL commit_done: {done,err,full}=%b required 100",
                               {bus.cfg_done, bus.cfg_err, bus.cfg_full});
        end
        tick();
        n_checks++;
        if (bus.cfg_done !== 1'b0) begin
            n_fail++; $display("FAIL done_one_cycle: cfg_done=%b required 0", bus.cfg_done);
        end
        bus.from_S[0] = 1'b1;
        repeat (3) tick();
        bus.from_S[0] = 1'b0;
        tick();
        n_checks++;
        if (bus.to_N[0] !== 1'b1) begin
            n_fail++; $display("FAIL reg_latency_1: to_N[0]=%b required 1", bus.to_N[0]);
        end
        tick();
        n_checks++;
        if (bus.to_N[0] !== 1'b0) begin
            n_fail++; $display("FAIL reg_latency_2: to_N[0]=%b required 0", bus.to_N[0]);
        end
        n_checks++;
        if (bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL reg_all: to_N=%h required %h", bus.to_N, exp_to_n());
        end
    endtask

    task automatic test_short_commit();
        logic [CFG_BITS-1:0] w;
        w = chain_word(rnd_w() ^ {rnd_w(), rnd_w()}, 1'b0);
        shift_word(w, CFG_BITS-1);
        n_checks++;
        if (bus.cfg_full !== 1'b0) begin
            n_fail++; $display("FAIL short_not_full: cfg_full=%b required 0", bus.cfg_full);
        end
        pulse_commit();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err, bus.cfg_full} !== 3'b010) begin
            n_fail++; $display("FAIL short_commit_err: {done,err,full}=%b required 010",
                               {bus.cfg_done, bus.cfg_err, bus.cfg_full});
        end
        n_checks++;
        if (bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL short_modes_kept: to_N=%h required %h", bus.to_N, exp_to_n());
        end
        bus.cfg_shift_en = 1'b1;
        bus.cfg_din      = w[0];
        tick();
        bus.cfg_shift_en = 1'b0;
        n_checks++;
        if (bus.cfg_err !== 1'b0 || bus.cfg_full !== 1'b1) begin
            n_fail++; $display("FAIL last_shift: err=%b full=%b required err=0 full=1", bus.cfg_err, bus.cfg_full);
        end
        pulse_commit();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10) begin
            n_fail++; $display("FAIL full_commit_done: {done,err}=%b required 10", {bus.cfg_done, bus.cfg_err});
        end
        for (int c = 0; c < 20; c++) begin
            bus.from_S = rnd_w();
            tick();
            n_checks++;
            if (bus.to_N !== exp_to_n()) begin
                n_fail++; $display("FAIL mixed_modes c%0d: to_N=%h required %h", c, bus.to_N, exp_to_n());
            end
        end
    endtask

    task automatic test_hold();
        logic [2*NW-1:0] modes;
        logic held, prev;
        modes = uniform_modes(2'b01);
        shift_word(chain_word(modes, 1'b0), CFG_BITS);
        pulse_commit();
        modes[11:10] = 2'b11;
        shift_word(chain_word(modes, 1'b0), CFG_BITS);
        bus.from_S = ~bus.from_S;
        pulse_commit();
        n_checks++;
        if (bus.cfg_done !== 1'b1) begin
            n_fail++; $display("FAIL hold_commit: cfg_done=%b required 1", bus.cfg_done);
        end
        held = bus.to_N[5];
        for (int c = 0; c < 6; c++) begin
            bus.from_S = ~bus.from_S;
            tick();
            n_checks++;
            if (bus.to_N[5] !== held || bus.to_N !== exp_to_n()) begin
                n_fail++; $display("FAIL hold_frozen c%0d: to_N=%h required %h (ch5 %b)",
                                   c, bus.to_N, exp_to_n(), held);
            end
        end
        modes[11:10] = 2'b01;
        shift_word(chain_word(modes, 1'b0), CFG_BITS);
        bus.from_S = ~bus.from_S;
        pulse_commit();
        n_checks++;
        if (bus.cfg_done !== 1'b1) begin
            n_fail++; $display("FAIL resume_commit: cfg_done=%b required 1", bus.cfg_done);
        end
        prev = bus.to_N[5];
        for (int c = 0; c < 8; c++) begin
            bus.from_S = ~bus.from_S;
            tick();
            n_checks++;
            if (bus.to_N !== exp_to_n() || (c >= 2 && bus.to_N[5] === prev)) begin
                n_fail++; $display("FAIL hold_resume c%0d: to_N=%h required %h", c, bus.to_N, exp_to_n());
            end
            prev = bus.to_N[5];
        end
    endtask

    task automatic test_shift_commit_same();
        shift_word(chain_word({rnd_w(), rnd_w()}, 1'b0), CFG_BITS);
        bus.cfg_shift_en = 1'b1;
        bus.cfg_din      = ~sh_q[1];
        bus.cfg_commit   = 1'b1;
        tick();
        bus.cfg_shift_en = 1'b0;
        bus.cfg_commit   = 1'b0;
        n_checks++;
        if ({bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err} !== exp_flags()) begin
            n_fail++; $display("FAIL shift_commit_flags: {dout,full,done,err}=%b required %b",
                               {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err}, exp_flags());
        end
        n_checks++;
        if (bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL shift_commit_modes: to_N=%h required %h", bus.to_N, exp_to_n());
        end
    endtask

    task automatic test_back_to_back();
        shift_word(chain_word(uniform_modes(2'b10), 1'b0), CFG_BITS);
        bus.cfg_commit = 1'b1;
        tick();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_first: {done,err}=%b required 10", {bus.cfg_done, bus.cfg_err});
        end
        tick();
        bus.cfg_commit = 1'b0;
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_second: {done,err}=%b required 01", {bus.cfg_done, bus.cfg_err});
        end
        n_checks++;
        if (bus.to_N !== '0) begin
            n_fail++; $display("FAIL tie_all: to_N=%h required 0", bus.to_N);
        end
    endtask

    task automatic test_saturate();
        shift_word(chain_word({rnd_w(), rnd_w()}, 1'b0), CFG_BITS);
        for (int c = 0; c < 5; c++) begin
            bus.cfg_shift_en = 1'b1;
            bus.cfg_din      = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if ({bus.cfg_dout, bus.cfg_full} !== exp_flags()[3:2]) begin
                n_fail++; $display("FAIL saturate c%0d: {dout,full}=%b required %b",
                                   c, {bus.cfg_dout, bus.cfg_full}, exp_flags()[3:2]);
            end
        end
        bus.cfg_shift_en = 1'b0;
        pulse_commit();
`ifndef SAUBER_TERM_CFG_PARITY_EN
        n_checks++;
        if (bus.cfg_done !== 1'b1) begin
            n_fail++; $display("FAIL saturate_commit: cfg_done=%b required 1", bus.cfg_done);
        end
`endif
        bus.from_S = rnd_w();
        tick();
        n_checks++;
        if (bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL saturate_modes: to_N=%h required %h", bus.to_N, exp_to_n());
        end
    endtask

    task automatic test_reset_mid();
        shift_word(chain_word(uniform_modes(2'b01), 1'b0), 40);
        bus.cfg_shift_en = 1'b1;
        bus.cfg_din      = 1'b1;
        #2 UserRSTn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.to_N !== bus.from_S ||
            {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_shift: to_N=%h from_S=%h flags=%b",
                               bus.to_N, bus.from_S, {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err});
        end
        bus.cfg_shift_en = 1'b0;
        bus.cfg_commit   = 1'b1;
        @(posedge UserCLK);
        #1;
        n_checks++;
        if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_commit: done=%b err=%b required 0 0", bus.cfg_done, bus.cfg_err);
        end
        bus.cfg_commit = 1'b0;
        UserRSTn = 1'b1;
        @(posedge UserCLK);
        #1;
        shift_word(chain_word(uniform_modes(2'b01), 1'b0), CFG_BITS-1);
        n_checks++;
        if (bus.cfg_full !== 1'b0 || bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL cnt_cleared: full=%b to_N=%h required 0 %h", bus.cfg_full, bus.to_N, exp_to_n());
        end
    endtask

`ifdef SAUBER_TERM_CFG_PARITY_EN
    task automatic test_parity();
        shift_word(chain_word(uniform_modes(2'b10), 1'b1), CFG_BITS);
        pulse_commit();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b01 || bus.to_N !== exp_to_n()) begin
            n_fail++; $display("FAIL parity_bad: {done,err}=%b to_N=%h required 01 %h",
                               {bus.cfg_done, bus.cfg_err}, bus.to_N, exp_to_n());
        end
        shift_word(chain_word(uniform_modes(2'b10), 1'b0), CFG_BITS);
        pulse_commit();
        n_checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10 || bus.to_N !== '0) begin
            n_fail++; $display("FAIL parity_good: {done,err}=%b to_N=%h required 10 0",
                               {bus.cfg_done, bus.cfg_err}, bus.to_N);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.from_S       = rnd_w();
            bus.cfg_shift_en = ($urandom_range(0, 3) != 0);
            bus.cfg_din      = 1'($urandom_range(0, 1));
            bus.cfg_commit   = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++;
            if (bus.to_N !== exp_to_n() ||
                {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err} !== exp_flags()) begin
                n_fail++; $display("FAIL random c%0d: to_N=%h flags=%b required %h %b", c, bus.to_N,
                                   {bus.cfg_dout, bus.cfg_full, bus.cfg_done, bus.cfg_err}, exp_to_n(), exp_flags());
            end
        end
        bus.cfg_shift_en = 1'b0;
        bus.cfg_commit   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_reg();
        test_short_commit();
        test_hold();
        test_shift_commit_same();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
`ifdef SAUBER_TERM_CFG_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
